// File: rtl/atpg_entry_ctrl.sv
// ATPG entry controller: debounces TST, receives a serial unlock key plus mode code on SCL/SDA,
// and drives the test-mode controls. Define ATPG_LOCKOUT_EN to enable failed-attempt lockout.
module atpg_entry_ctrl #(
    parameter int               KEY_W    = 16,
    parameter logic [KEY_W-1:0] KEY_VAL  = 16'hA55A,
    parameter int               SEL_W    = 3,
    parameter int               DEB_CYC  = 8,
    parameter int               MAX_FAIL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tst_i,
    input  logic             scl_i,
    input  logic             sda_i,
    input  logic             se_pin_i,
    output logic             atpg_mode_o,
    output logic             scan_en_o,
    output logic [SEL_W-1:0] test_sel_o,
    output logic             locked_o,
    output logic             busy_o
);

    localparam int TOT_W = KEY_W + SEL_W;
    localparam int CNT_W = $clog2(TOT_W + 1);
    localparam int DEB_W = $clog2(DEB_CYC + 1);

`ifdef ATPG_LOCKOUT_EN
    typedef enum logic [2:0] {IDLE, SHIFT, CHECK, ACTIVE, FAIL, LOCK} state_t;
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;
`else
    typedef enum logic [2:0] {IDLE, SHIFT, CHECK, ACTIVE, FAIL} state_t;
`endif

    state_t             state_q, state_d;
    logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic               tst_f_q, tst_f_d;
    logic               scl_q;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [TOT_W-1:0]   shreg_q, shreg_d;
    logic               scan_en_q, scan_en_d;
    logic [SEL_W-1:0]   test_sel_q, test_sel_d;
    logic               tst_diff, tst_flip, scl_rise, key_ok;

    // tst_f flips on the edge that completes DEB_CYC consecutive differing cycles
    always_comb begin
        tst_diff  = tst_i ^ tst_f_q;
        tst_flip  = tst_diff && (deb_cnt_q == DEB_W'(DEB_CYC - 1));
        deb_cnt_d = (tst_diff && !tst_flip) ? deb_cnt_q + DEB_W'(1) : '0;
        tst_f_d   = tst_f_q ^ tst_flip;
        scl_rise  = scl_i & ~scl_q;
        key_ok    = (shreg_q[TOT_W-1:SEL_W] == KEY_VAL);
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
`ifdef ATPG_LOCKOUT_EN
        fail_cnt_d = fail_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // Every path back to IDLE leaves tst_f low, so a high level here is a fresh rise
                if (tst_f_q) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (!tst_f_q) begin
                    state_d = IDLE;
                end else if (scl_rise) begin
                    shreg_d   = {shreg_q[TOT_W-2:0], sda_i};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(TOT_W - 1)) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (key_ok) begin
                    state_d = ACTIVE;
`ifdef ATPG_LOCKOUT_EN
                    fail_cnt_d = '0;
`endif
                end else begin
                    state_d = FAIL;
`ifdef ATPG_LOCKOUT_EN
                    fail_cnt_d = (fail_cnt_q == FAIL_W'(MAX_FAIL)) ? fail_cnt_q
                                                                   : fail_cnt_q + FAIL_W'(1);
                    if (fail_cnt_d == FAIL_W'(MAX_FAIL)) begin
                        state_d = LOCK;
                    end
`endif
                end
            end
            ACTIVE: begin
                if (!tst_f_q) begin
                    state_d = IDLE;
                end
            end
            FAIL: begin
                if (!tst_f_q) begin
                    state_d = IDLE;
                end
            end
`ifdef ATPG_LOCKOUT_EN
            LOCK: begin
                state_d = LOCK;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered controls follow the next state so they drop on the same edge ACTIVE is left
        scan_en_d  = (state_d == ACTIVE) && se_pin_i;
        test_sel_d = '0;
        if (state_d == ACTIVE) begin
            test_sel_d = (state_q == CHECK) ? shreg_q[SEL_W-1:0] : test_sel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            deb_cnt_q  <= '0;
            tst_f_q    <= 1'b0;
            scl_q      <= 1'b0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            scan_en_q  <= 1'b0;
            test_sel_q <= '0;
        end else begin
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            tst_f_q    <= tst_f_d;
            scl_q      <= scl_i;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            scan_en_q  <= scan_en_d;
            test_sel_q <= test_sel_d;
        end
    end

`ifdef ATPG_LOCKOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fail_cnt_q <= '0;
        end else begin
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign locked_o = (state_q == LOCK);
`else
    assign locked_o = 1'b0;
`endif

    assign busy_o      = (state_q == SHIFT);
    assign atpg_mode_o = (state_q == ACTIVE);
    assign scan_en_o   = scan_en_q;
    assign test_sel_o  = test_sel_q;

endmodule

// File: tb/tb_atpg_entry_ctrl.sv
// Directed testbench for atpg_entry_ctrl: key entry, scan enable, wrong key, abort,
// retry/lockout behaviour and reset while active.
module tb_atpg_entry_ctrl;

    logic       clk;
    logic       rst;
    logic       tst_i;
    logic       scl_i;
    logic       sda_i;
    logic       se_pin_i;
    logic       atpg_mode_o;
    logic       scan_en_o;
    logic [2:0] test_sel_o;
    logic       locked_o;
    logic       busy_o;

    int total;
    int bad;

    localparam logic [15:0] GOOD_KEY = 16'hA55A;
    localparam logic [15:0] BAD_KEY  = 16'hA55B;

    atpg_entry_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .tst_i      (tst_i),
        .scl_i      (scl_i),
        .sda_i      (sda_i),
        .se_pin_i   (se_pin_i),
        .atpg_mode_o(atpg_mode_o),
        .scan_en_o  (scan_en_o),
        .test_sel_o (test_sel_o),
        .locked_o   (locked_o),
        .busy_o     (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        sda_i = b;
        scl_i = 1'b1;
        tick();
        scl_i = 1'b0;
        tick();
    endtask

    task automatic send_word(input logic [18:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(w[18-i]);
        end
        $display("sent %0d bits of word 0x%05h", n, w);
    endtask

    // Raise TST and wait (bounded) for key reception to start
    task automatic enter_shift(input string name);
        int k;
        tst_i = 1'b1;
        k = 0;
        while (busy_o !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        total++;
        if (busy_o !== 1'b1) begin
            bad++;
            $display("FAIL %s_enter: busy_o got %b want 1 within 20 cycles", name, busy_o);
        end
    endtask

    task automatic release_tst();
        tst_i = 1'b0;
        tick(12);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        total++;
        if (atpg_mode_o !== 1'b0) begin bad++; $display("FAIL reset_atpg: got %b want 0", atpg_mode_o); end
        total++;
        if (scan_en_o !== 1'b0) begin bad++; $display("FAIL reset_scan_en: got %b want 0", scan_en_o); end
        total++;
        if (test_sel_o !== 3'b000) begin bad++; $display("FAIL reset_test_sel: got %b want 000", test_sel_o); end
        total++;
        if (locked_o !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", locked_o); end
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        rst = 1'b0;
        tick();
        $display("reset done");
    endtask

    task automatic test_correct_key();
        logic [18:0] w;
        w = {GOOD_KEY, 3'b101};
        tst_i = 1'b1;
        tick(8);
        total++;
        if (busy_o !== 1'b0) begin bad++; $display("FAIL deb_rise_early: busy_o got %b want 0", busy_o); end
        tick();
        total++;
        if (busy_o !== 1'b1) begin bad++; $display("FAIL deb_rise: busy_o got %b want 1", busy_o); end
        send_word(w, 18);
        total++;
        if (busy_o !== 1'b1) begin bad++; $display("FAIL shift_busy: got %b want 1", busy_o); end
        sda_i = w[0];
        scl_i = 1'b1;
        tick();
        total++;
        if (atpg_mode_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL check_cycle: atpg=%b busy=%b want atpg=0 busy=0", atpg_mode_o, busy_o);
        end
        scl_i = 1'b0;
        tick();
        total++;
        if (atpg_mode_o !== 1'b1) begin bad++; $display("FAIL key_ok_atpg: got %b want 1", atpg_mode_o); end
        total++;
        if (test_sel_o !== 3'b101) begin bad++; $display("FAIL key_ok_sel: got %b want 101", test_sel_o); end
        total++;
        if (scan_en_o !== 1'b0) begin bad++; $display("FAIL key_ok_scan_en: got %b want 0", scan_en_o); end
        $display("correct key entered");
    endtask

    task automatic test_scan_en();
        se_pin_i = 1'b1;
        #1;
        total++;
        if (scan_en_o !== 1'b0) begin bad++; $display("FAIL se_latency: got %b want 0", scan_en_o); end
        tick();
        total++;
        if (scan_en_o !== 1'b1) begin bad++; $display("FAIL se_follow_1: got %b want 1", scan_en_o); end
        se_pin_i = 1'b0;
        tick();
        total++;
        if (scan_en_o !== 1'b0) begin bad++; $display("FAIL se_follow_0: got %b want 0", scan_en_o); end
        send_word(19'h7FFFF, 3);
        total++;
        if (atpg_mode_o !== 1'b1 || test_sel_o !== 3'b101 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL extra_scl: atpg=%b sel=%b busy=%b want 1 101 0", atpg_mode_o, test_sel_o, busy_o);
        end
        se_pin_i = 1'b1;
        tick();
        tst_i = 1'b0;
        tick(8);
        total++;
        if (atpg_mode_o !== 1'b1 || scan_en_o !== 1'b1) begin
            bad++;
            $display("FAIL release_early: atpg=%b scan_en=%b want 1 1", atpg_mode_o, scan_en_o);
        end
        tick();
        total++;
        if (atpg_mode_o !== 1'b0 || scan_en_o !== 1'b0 || test_sel_o !== 3'b000) begin
            bad++;
            $display("FAIL release: atpg=%b scan_en=%b sel=%b want 0 0 000", atpg_mode_o, scan_en_o, test_sel_o);
        end
        se_pin_i = 1'b0;
        tick(3);
        $display("scan enable and release done");
    endtask

    task automatic test_wrong_key();
        enter_shift("wrong");
        send_word({BAD_KEY, 3'b101}, 19);
        tick();
        total++;
        if (atpg_mode_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL wrong_key: atpg=%b busy=%b want 0 0", atpg_mode_o, busy_o);
        end
        tst_i = 1'b0;
        tick(5);
        tst_i = 1'b1;
        tick(12);
        total++;
        if (busy_o !== 1'b0 || atpg_mode_o !== 1'b0) begin
            bad++;
            $display("FAIL glitch_in_fail: busy=%b atpg=%b want 0 0", busy_o, atpg_mode_o);
        end
        release_tst();
        enter_shift("retry");
        send_word({GOOD_KEY, 3'b010}, 19);
        total++;
        if (atpg_mode_o !== 1'b1 || test_sel_o !== 3'b010) begin
            bad++;
            $display("FAIL retry: atpg=%b sel=%b want 1 010", atpg_mode_o, test_sel_o);
        end
        release_tst();
        $display("wrong key and retry done");
    endtask

    task automatic test_abort();
        enter_shift("abort");
        send_word({GOOD_KEY, 3'b011}, 7);
        tst_i = 1'b0;
        tick(8);
        total++;
        if (busy_o !== 1'b1) begin bad++; $display("FAIL abort_early: busy got %b want 1", busy_o); end
        tick();
        total++;
        if (busy_o !== 1'b0 || atpg_mode_o !== 1'b0) begin
            bad++;
            $display("FAIL abort: busy=%b atpg=%b want 0 0", busy_o, atpg_mode_o);
        end
        tick(3);
        enter_shift("after_abort");
        send_word({GOOD_KEY, 3'b011}, 12);
        total++;
        if (busy_o !== 1'b1) begin bad++; $display("FAIL abort_count: busy got %b want 1", busy_o); end
        send_word({GOOD_KEY, 3'b011} << 12, 7);
        total++;
        if (atpg_mode_o !== 1'b1 || test_sel_o !== 3'b011) begin
            bad++;
            $display("FAIL after_abort: atpg=%b sel=%b want 1 011", atpg_mode_o, test_sel_o);
        end
        release_tst();
        $display("abort done");
    endtask

    task automatic test_lockout();
        for (int a = 1; a <= 3; a++) begin
            enter_shift("bad_attempt");
            send_word({BAD_KEY, 3'b001}, 19);
            tick();
            total++;
`ifdef ATPG_LOCKOUT_EN
            if (locked_o !== (a == 3)) begin
                bad++;
                $display("FAIL lock_attempt%0d: locked got %b want %b", a, locked_o, (a == 3));
            end
`else
            if (locked_o !== 1'b0) begin
                bad++;
                $display("FAIL nolock_attempt%0d: locked got %b want 0", a, locked_o);
            end
`endif
            release_tst();
        end
`ifdef ATPG_LOCKOUT_EN
        tst_i = 1'b1;
        tick(15);
        total++;
        if (busy_o !== 1'b0 || locked_o !== 1'b1) begin
            bad++;
            $display("FAIL locked_ignores_tst: busy=%b locked=%b want 0 1", busy_o, locked_o);
        end
        send_word({GOOD_KEY, 3'b110}, 19);
        total++;
        if (atpg_mode_o !== 1'b0) begin bad++; $display("FAIL locked_key: atpg got %b want 0", atpg_mode_o); end
        tst_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (locked_o !== 1'b0) begin bad++; $display("FAIL unlock_rst: locked got %b want 0", locked_o); end
`endif
        enter_shift("after_fails");
        send_word({GOOD_KEY, 3'b110}, 19);
        total++;
        if (atpg_mode_o !== 1'b1 || test_sel_o !== 3'b110) begin
            bad++;
            $display("FAIL after_fails: atpg=%b sel=%b want 1 110", atpg_mode_o, test_sel_o);
        end
        release_tst();
        $display("retry limit behaviour done");
    endtask

    task automatic test_reset_active();
        enter_shift("rst_active");
        send_word({GOOD_KEY, 3'b111}, 19);
        se_pin_i = 1'b1;
        tick();
        total++;
        if (atpg_mode_o !== 1'b1 || scan_en_o !== 1'b1) begin
            bad++;
            $display("FAIL pre_rst: atpg=%b scan_en=%b want 1 1", atpg_mode_o, scan_en_o);
        end
        rst = 1'b1;
        tick();
        total++;
        if (atpg_mode_o !== 1'b0 || scan_en_o !== 1'b0 || test_sel_o !== 3'b000 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_active: atpg=%b scan_en=%b sel=%b busy=%b want 0 0 000 0",
                     atpg_mode_o, scan_en_o, test_sel_o, busy_o);
        end
        rst = 1'b0;
        tick();
        total++;
        if (busy_o !== 1'b0 || atpg_mode_o !== 1'b0) begin
            bad++;
            $display("FAIL post_rst_idle: busy=%b atpg=%b want 0 0", busy_o, atpg_mode_o);
        end
        se_pin_i = 1'b0;
        tst_i = 1'b0;
        tick(3);
        $display("reset in active done");
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        tst_i    = 1'b0;
        scl_i    = 1'b0;
        sda_i    = 1'b0;
        se_pin_i = 1'b0;
        tick();
        test_reset();
        test_correct_key();
        test_scan_en();
        test_wrong_key();
        test_abort();
        test_lockout();
        test_reset_active();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
